id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the EX-stage ALU in the pipelined MIPS core.
- Registers decoded operands and ALU control from ID, then drives ALU inputs A/B through EX/MEM and MEM/WB forwarding muxes.
- Detects load-use hazards, stalls IF/ID and inserts bubbles.
- Supports branch flush and whole-pipe hold.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_valid  in  1  ID holds a real instruction
- i_rs, i_rt, i_rd  in  REG_AW each  source/dest register numbers from ID
- i_rdata_a, i_rdata_b  in  DATA_W each  register-file read data
- i_imm  in  DATA_W  extended immediate
- i_use_imm  in  1  ALU B = immediate
- i_dst_rt  in  1  dest = rt (else rd)
- i_SA  in  5  shift amount
- i_ShiftOp  in  2  ALU shift control
- i_ArithmeticOp  in  1  ALU arithmetic control
- i_LogicalOp  in  2  ALU logical control
- i_ALUselection  in  2  ALU result select
- i_reg_write, i_mem_read, i_mem_write  in  1 each  control flags
- i_flush  in  1  branch taken; kill the ID instruction
- i_hold  in  1  downstream stall; freeze the stage
- i_exmem_reg_write  in  1  EX/MEM writes a register
- i_exmem_dst  in  REG_AW  EX/MEM destination register
- i_exmem_data  in  DATA_W  EX/MEM ALU result
- i_memwb_reg_write  in  1  MEM/WB writes a register
- i_memwb_dst  in  REG_AW  MEM/WB destination register
- i_memwb_data  in  DATA_W  MEM/WB writeback data
- o_A, o_B  out  DATA_W each  ALU operands (forwarded)
- o_store_data  out  DATA_W  forwarded rt value for stores
- o_SA, o_ShiftOp, o_ArithmeticOp, o_LogicalOp, o_ALUselection  out  5/2/1/2/2  registered ALU controls
- o_valid, o_reg_write, o_mem_read, o_mem_write  out  1 each  registered flags
- o_dst  out  REG_AW  resolved destination register
- o_stall  out  1  hold PC and IF/ID this cycle

Behaviour:
- Register update at rising i_clk, priority order:
  1. i_rst_n=0: every register is 0. So all outputs are 0, o_valid=0, and o_stall=0.
  2. i_hold=1: all registers keep their values. A flush or load-use condition in the same cycle is ignored; ID must keep presenting it.
  3. i_flush=1: load a bubble. o_valid, o_reg_write, o_mem_read, o_mem_write = 0; other fields don't-care, implemented as 0.
  4. Load-use hazard: load a bubble, same as 3.
  5. Otherwise: capture all ID inputs. o_dst = i_dst_rt ? i_rt : i_rd. Flags are ANDed with i_valid.
- Load-use hazard (combinational):
  - Condition: o_valid & o_mem_read & o_dst!=0 & i_valid & (o_dst==i_rs | (o_dst==i_rt & (!i_use_imm | i_mem_write))).
  - o_stall = hazard | i_hold; forced 0 while i_rst_n=0.
  - Flush has priority over hazard bubble, but o_stall still follows the hazard equation.
  - Stall lasts exactly one cycle per load; the stalled instruction enters on the next edge.
- Forwarding (combinational, on registered rs/rt):
  - Source fwd(r): if i_exmem_reg_write & i_exmem_dst==r & r!=0, use i_exmem_data.
  - Else if i_memwb_reg_write & i_memwb_dst==r & r!=0, use i_memwb_data.
  - Else use the registered register-file data.
  - EX/MEM beats MEM/WB on simultaneous match. $0 is never forwarded.
- Operand outputs:
  - o_A = fwd(rs).
  - o_B = use_imm ? imm : fwd(rt).
  - o_store_data = fwd(rt) always.
- Latency: ID inputs reach outputs 1 cycle later. Forwarding is zero-latency.
- Bubble outputs: forwarding muxes still evaluate; o_A/o_B are don't-care but deterministic.

Test Plan:
- Reset mid-operation: pipe full, i_rst_n=0 for 1 cycle → all outputs 0, o_stall=0 on the next edge, even with i_hold=1.
- Capture: i_valid=1, i_rdata_a=5, i_rdata_b=7, i_rs=1, i_rt=2, no forwarding; next cycle → o_A=5, o_B=7, controls match inputs.
  - Same with i_use_imm=1, i_imm=0xFFFF_FFF0 → o_B=0xFFFF_FFF0, o_store_data=7.
- Double forward: registered rs=3; i_exmem_dst=3 with data 0xAA; i_memwb_dst=3 with data 0xBB; both reg_write=1 → o_A=0xAA.
  - Drop exmem reg_write → o_A=0xBB.
  - rs=0 with both dst=0 → o_A = register-file value.
- Load-use: EX holds lw to $4 (o_mem_read=1, o_dst=4); ID holds add using rs=4 → o_stall=1 for one cycle, next o_valid=0.
  - The following cycle add is captured, and o_A takes the MEM/WB data when i_memwb_dst=4.
  - Variant: addi with rt=4 and use_imm=1 → no stall.
- Flush vs hazard: i_flush=1 together with a load-use condition → bubble loaded, o_stall=1.
  - i_flush=1 alone → o_valid=0, o_reg_write=0 next cycle.
- Hold: i_hold=1 for 3 cycles with changing ID inputs and i_flush=1 → registered outputs unchanged, o_stall=1 throughout.
  - On release, the current ID values are captured.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of the pipelined MIPS core. It captures the decoded
// operands and ALU controls from ID, then presents forwarded ALU operands to EX.
// It also detects load-use hazards, inserts bubbles on a hazard or a branch
// flush, and freezes completely while the downstream pipe holds.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge) and synchronous active-low reset
//   i_valid .. i_mem_write  decoded instruction fields from ID
//   i_flush                 branch taken; the ID instruction becomes a bubble
//   i_hold                  downstream stall; every register keeps its value
//   i_exmem_*, i_memwb_*    writeback info used by the forwarding muxes
//   o_A, o_B, o_store_data  forwarded ALU operands and store data
//   o_SA .. o_ALUselection  registered ALU controls
//   o_valid .. o_mem_write  registered flags
//   o_dst                   resolved destination register
//   o_stall                 holds the PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [DATA_W-1:0] i_rdata_a,
  input  logic [DATA_W-1:0] i_rdata_b,
  input  logic [DATA_W-1:0] i_imm,
  input  logic              i_use_imm,
  input  logic              i_dst_rt,
  input  logic [4:0]        i_SA,
  input  logic [1:0]        i_ShiftOp,
  input  logic              i_ArithmeticOp,
  input  logic [1:0]        i_LogicalOp,
  input  logic [1:0]        i_ALUselection,
  input  logic              i_reg_write,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_flush,
  input  logic              i_hold,
  input  logic              i_exmem_reg_write,
  input  logic [REG_AW-1:0] i_exmem_dst,
  input  logic [DATA_W-1:0] i_exmem_data,
  input  logic              i_memwb_reg_write,
  input  logic [REG_AW-1:0] i_memwb_dst,
  input  logic [DATA_W-1:0] i_memwb_data,
  output logic [DATA_W-1:0] o_A,
  output logic [DATA_W-1:0] o_B,
  output logic [DATA_W-1:0] o_store_data,
  output logic [4:0]        o_SA,
  output logic [1:0]        o_ShiftOp,
  output logic              o_ArithmeticOp,
  output logic [1:0]        o_LogicalOp,
  output logic [1:0]        o_ALUselection,
  output logic              o_valid,
  output logic              o_reg_write,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [REG_AW-1:0] o_dst,
  output logic              o_stall
);

  logic              r_valid;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_dst;
  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;
  logic [DATA_W-1:0] r_imm;
  logic              r_use_imm;
  logic [4:0]        r_sa;
  logic [1:0]        r_shift_op;
  logic              r_arith_op;
  logic [1:0]        r_logical_op;
  logic [1:0]        r_alu_sel;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;

  logic              w_hazard;
  logic              w_bubble;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // A load in EX whose destination ID needs now. rt only counts when it feeds
  // the ALU (no immediate) or is the data of a store.
  always_comb begin
    w_hazard = r_valid && r_mem_read && (r_dst != '0) && i_valid &&
               ((r_dst == i_rs) ||
                ((r_dst == i_rt) && (!i_use_imm || i_mem_write)));
    w_bubble = i_flush || w_hazard;
    o_stall  = i_rst_n && (w_hazard || i_hold);
  end

  // EX/MEM is the younger result, so it wins over MEM/WB; $0 never forwards.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_AW-1:0] r,
    input logic [DATA_W-1:0] rf_data,
    input logic              exmem_we,
    input logic [REG_AW-1:0] exmem_dst,
    input logic [DATA_W-1:0] exmem_data,
    input logic              memwb_we,
    input logic [REG_AW-1:0] memwb_dst,
    input logic [DATA_W-1:0] memwb_data
  );
    if (r == '0) begin
      return rf_data;
    end else if (exmem_we && (exmem_dst == r)) begin
      return exmem_data;
    end else if (memwb_we && (memwb_dst == r)) begin
      return memwb_data;
    end
    return rf_data;
  endfunction

  always_comb begin
    w_fwd_rs = fwd(r_rs, r_rdata_a, i_exmem_reg_write, i_exmem_dst, i_exmem_data,
                   i_memwb_reg_write, i_memwb_dst, i_memwb_data);
    w_fwd_rt = fwd(r_rt, r_rdata_b, i_exmem_reg_write, i_exmem_dst, i_exmem_data,
                   i_memwb_reg_write, i_memwb_dst, i_memwb_data);
    o_A          = w_fwd_rs;
    o_B          = r_use_imm ? r_imm : w_fwd_rt;
    o_store_data = w_fwd_rt;
  end

  // Reset and bubbles both clear every field; hold overrides flush and hazard.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || (!i_hold && w_bubble)) begin
      r_valid      <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_dst        <= '0;
      r_rdata_a    <= '0;
      r_rdata_b    <= '0;
      r_imm        <= '0;
      r_use_imm    <= 1'b0;
      r_sa         <= '0;
      r_shift_op   <= '0;
      r_arith_op   <= 1'b0;
      r_logical_op <= '0;
      r_alu_sel    <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else if (!i_hold) begin
      r_valid      <= i_valid;
      r_rs         <= i_rs;
      r_rt         <= i_rt;
      r_dst        <= i_dst_rt ? i_rt : i_rd;
      r_rdata_a    <= i_rdata_a;
      r_rdata_b    <= i_rdata_b;
      r_imm        <= i_imm;
      r_use_imm    <= i_use_imm;
      r_sa         <= i_SA;
      r_shift_op   <= i_ShiftOp;
      r_arith_op   <= i_ArithmeticOp;
      r_logical_op <= i_LogicalOp;
      r_alu_sel    <= i_ALUselection;
      r_reg_write  <= i_reg_write && i_valid;
      r_mem_read   <= i_mem_read && i_valid;
      r_mem_write  <= i_mem_write && i_valid;
    end
  end

  assign o_SA           = r_sa;
  assign o_ShiftOp      = r_shift_op;
  assign o_ArithmeticOp = r_arith_op;
  assign o_LogicalOp    = r_logical_op;
  assign o_ALUselection = r_alu_sel;
  assign o_valid        = r_valid;
  assign o_reg_write    = r_reg_write;
  assign o_mem_read     = r_mem_read;
  assign o_mem_write    = r_mem_write;
  assign o_dst          = r_dst;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rdata_a, rdata_b, imm;
  logic        use_imm, dst_rt;
  logic [4:0]  sa;
  logic [1:0]  shift_op;
  logic        arith_op;
  logic [1:0]  logical_op, alu_sel;
  logic        reg_write, mem_read, mem_write;
  logic        flush, hold;
  logic        exmem_rw;
  logic [4:0]  exmem_dst;
  logic [31:0] exmem_data;
  logic        memwb_rw;
  logic [4:0]  memwb_dst;
  logic [31:0] memwb_data;

  logic [31:0] o_A, o_B, o_store_data;
  logic [4:0]  o_SA;
  logic [1:0]  o_ShiftOp;
  logic        o_ArithmeticOp;
  logic [1:0]  o_LogicalOp, o_ALUselection;
  logic        o_valid, o_reg_write, o_mem_read, o_mem_write;
  logic [4:0]  o_dst;
  logic        o_stall;

  int tests = 0;
  int fails = 0;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
    .i_rs(rs), .i_rt(rt), .i_rd(rd),
    .i_rdata_a(rdata_a), .i_rdata_b(rdata_b), .i_imm(imm),
    .i_use_imm(use_imm), .i_dst_rt(dst_rt), .i_SA(sa), .i_ShiftOp(shift_op),
    .i_ArithmeticOp(arith_op), .i_LogicalOp(logical_op), .i_ALUselection(alu_sel),
    .i_reg_write(reg_write), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_flush(flush), .i_hold(hold),
    .i_exmem_reg_write(exmem_rw), .i_exmem_dst(exmem_dst), .i_exmem_data(exmem_data),
    .i_memwb_reg_write(memwb_rw), .i_memwb_dst(memwb_dst), .i_memwb_data(memwb_data),
    .o_A(o_A), .o_B(o_B), .o_store_data(o_store_data),
    .o_SA(o_SA), .o_ShiftOp(o_ShiftOp), .o_ArithmeticOp(o_ArithmeticOp),
    .o_LogicalOp(o_LogicalOp), .o_ALUselection(o_ALUselection),
    .o_valid(o_valid), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_dst(o_dst), .o_stall(o_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of the ID/EX slot as the reference sees it.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, dst;
    logic [31:0] a, b, imm;
    logic        use_imm;
    logic [4:0]  sa;
    logic [1:0]  sh;
    logic        ar;
    logic [1:0]  lg, sel;
    logic        rw, mr, mw;
  } slot_t;

  slot_t m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return rf;
    if (exmem_rw && exmem_dst == r) return exmem_data;
    if (memwb_rw && memwb_dst == r) return memwb_data;
    return rf;
  endfunction

  function automatic logic ref_hazard();
    logic needs_rt;
    needs_rt = !use_imm || mem_write;
    return m.valid && m.mr && (m.dst != 5'd0) && valid &&
           ((m.dst == rs) || (m.dst == rt && needs_rt));
  endfunction

  task automatic check_all();
    chk("stall", 32'(o_stall), 32'(rst_n && (ref_hazard() || hold)));
    chk("A", o_A, ref_fwd(m.rs, m.a));
    chk("B", o_B, m.use_imm ? m.imm : ref_fwd(m.rt, m.b));
    chk("store", o_store_data, ref_fwd(m.rt, m.b));
    chk("SA", 32'(o_SA), 32'(m.sa));
    chk("ShiftOp", 32'(o_ShiftOp), 32'(m.sh));
    chk("ArithOp", 32'(o_ArithmeticOp), 32'(m.ar));
    chk("LogicOp", 32'(o_LogicalOp), 32'(m.lg));
    chk("ALUsel", 32'(o_ALUselection), 32'(m.sel));
    chk("valid", 32'(o_valid), 32'(m.valid));
    chk("reg_write", 32'(o_reg_write), 32'(m.rw));
    chk("mem_read", 32'(o_mem_read), 32'(m.mr));
    chk("mem_write", 32'(o_mem_write), 32'(m.mw));
    chk("dst", 32'(o_dst), 32'(m.dst));
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m = '0;
    end else if (hold) begin
      m = m;
    end else if (flush || ref_hazard()) begin
      m = '0;
    end else begin
      m.valid = valid;   m.rs = rs;       m.rt = rt;
      m.dst = dst_rt ? rt : rd;
      m.a = rdata_a;     m.b = rdata_b;   m.imm = imm;   m.use_imm = use_imm;
      m.sa = sa;         m.sh = shift_op; m.ar = arith_op;
      m.lg = logical_op; m.sel = alu_sel;
      m.rw = reg_write & valid;
      m.mr = mem_read & valid;
      m.mw = mem_write & valid;
    end
  endtask

  // Called at a negedge with inputs already driven.
  task automatic go();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1; valid = 0; rs = 0; rt = 0; rd = 0; rdata_a = 0; rdata_b = 0; imm = 0;
    use_imm = 0; dst_rt = 0; sa = 0; shift_op = 0; arith_op = 0; logical_op = 0;
    alu_sel = 0; reg_write = 0; mem_read = 0; mem_write = 0; flush = 0; hold = 0;
    exmem_rw = 0; exmem_dst = 0; exmem_data = 0;
    memwb_rw = 0; memwb_dst = 0; memwb_data = 0;
  endtask

  // lw $4, 8($5)
  task automatic drive_lw();
    idle();
    valid = 1; rs = 5; rt = 4; dst_rt = 1; use_imm = 1; imm = 8;
    mem_read = 1; reg_write = 1; rdata_a = 32'h1000;
  endtask

  initial begin
    m = '0;
    idle();
    rst_n = 0;
    @(negedge clk);
    go();
    go();

    // Capture with register operands
    idle();
    valid = 1; rs = 1; rt = 2; rd = 3; rdata_a = 5; rdata_b = 7;
    sa = 5'd9; shift_op = 2'd2; arith_op = 1; logical_op = 2'd1; alu_sel = 2'd3;
    reg_write = 1;
    go();
    idle();
    #1;
    chk("cap_A", o_A, 32'd5);
    chk("cap_B", o_B, 32'd7);
    chk("cap_dst", 32'(o_dst), 32'd3);
    chk("cap_SA", 32'(o_SA), 32'd9);
    chk("cap_ALUsel", 32'(o_ALUselection), 32'd3);
    chk("cap_rw", 32'(o_reg_write), 32'd1);

    // Capture with immediate
    valid = 1; rs = 1; rt = 2; rdata_a = 5; rdata_b = 7; use_imm = 1;
    imm = 32'hFFFF_FFF0; dst_rt = 1;
    go();
    idle();
    #1;
    chk("imm_B", o_B, 32'hFFFF_FFF0);
    chk("imm_store", o_store_data, 32'd7);
    chk("imm_dst", 32'(o_dst), 32'd2);

    // Reset mid-operation, with hold asserted
    go();
    valid = 1; rs = 3; rt = 4; rd = 6; rdata_a = 32'h55; reg_write = 1;
    go();
    rst_n = 0; hold = 1; valid = 1; rs = 7; reg_write = 1;
    #1;
    chk("rst_stall", 32'(o_stall), 32'd0);
    go();
    idle();
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_A", o_A, 32'd0);
    chk("rst_dst", 32'(o_dst), 32'd0);
    chk("rst_stall_after", 32'(o_stall), 32'd0);

    // Double forward on rs=3
    valid = 1; rs = 3; rt = 0; rdata_a = 32'h11; reg_write = 1;
    go();
    idle();
    exmem_rw = 1; exmem_dst = 3; exmem_data = 32'hAA;
    memwb_rw = 1; memwb_dst = 3; memwb_data = 32'hBB;
    #1;
    chk("fwd_both", o_A, 32'hAA);
    exmem_rw = 0;
    #1;
    chk("fwd_memwb", o_A, 32'hBB);
    go();
    // rs=0 is never forwarded
    idle();
    valid = 1; rs = 0; rdata_a = 32'h22;
    go();
    idle();
    exmem_rw = 1; exmem_dst = 0; exmem_data = 32'hAA;
    memwb_rw = 1; memwb_dst = 0; memwb_data = 32'hBB;
    #1;
    chk("fwd_zero", o_A, 32'h22);
    go();

    // Load-use: lw $4 then add using $4
    drive_lw();
    go();
    idle();
    valid = 1; rs = 4; rt = 6; rd = 7; reg_write = 1; rdata_a = 32'h1234;
    #1;
    chk("lu_stall", 32'(o_stall), 32'd1);
    go();
    #1;
    chk("lu_bubble", 32'(o_valid), 32'd0);
    chk("lu_stall_once", 32'(o_stall), 32'd0);
    memwb_rw = 1; memwb_dst = 4; memwb_data = 32'h44;
    go();
    idle();
    memwb_rw = 1; memwb_dst = 4; memwb_data = 32'h44;
    #1;
    chk("lu_valid", 32'(o_valid), 32'd1);
    chk("lu_fwd", o_A, 32'h44);
    chk("lu_dst", 32'(o_dst), 32'd7);
    go();

    // addi with rt=4 as destination: no stall
    drive_lw();
    go();
    idle();
    valid = 1; rs = 7; rt = 4; use_imm = 1; dst_rt = 1; reg_write = 1;
    #1;
    chk("addi_nostall", 32'(o_stall), 32'd0);
    go();

    // Flush coincident with load-use
    drive_lw();
    go();
    idle();
    valid = 1; rs = 4; rt = 6; rd = 7; reg_write = 1; flush = 1;
    #1;
    chk("fl_hz_stall", 32'(o_stall), 32'd1);
    go();
    idle();
    #1;
    chk("fl_hz_bubble", 32'(o_valid), 32'd0);
    // Flush alone
    valid = 1; rs = 1; rt = 2; rd = 3; reg_write = 1; flush = 1;
    go();
    idle();
    #1;
    chk("fl_valid", 32'(o_valid), 32'd0);
    chk("fl_rw", 32'(o_reg_write), 32'd0);

    // Hold for 3 cycles with flush and changing ID inputs
    valid = 1; rs = 9; rt = 10; rd = 11; rdata_a = 32'h100; rdata_b = 32'h200;
    reg_write = 1; sa = 5'd7; shift_op = 2'd2;
    go();
    for (int k = 0; k < 3; k++) begin
      hold = 1; flush = 1; valid = 1; rs = 5'(12 + k); rd = 5'(20 + k);
      rdata_a = 32'(k); sa = 5'(k);
      #1;
      chk("hold_stall", 32'(o_stall), 32'd1);
      chk("hold_A", o_A, 32'h100);
      chk("hold_dst", 32'(o_dst), 32'd11);
      chk("hold_SA", 32'(o_SA), 32'd7);
      chk("hold_valid", 32'(o_valid), 32'd1);
      go();
    end
    idle();
    valid = 1; rs = 13; rd = 14; rdata_a = 32'h300; reg_write = 1;
    go();
    idle();
    #1;
    chk("rel_A", o_A, 32'h300);
    chk("rel_dst", 32'(o_dst), 32'd14);
    chk("rel_valid", 32'(o_valid), 32'd1);

    // Randomized traffic on a small register range to provoke matches
    for (int n = 0; n < 400; n++) begin
      rst_n      = ($urandom_range(0, 49) != 0);
      hold       = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      valid      = ($urandom_range(0, 3) != 0);
      rs         = 5'($urandom_range(0, 7));
      rt         = 5'($urandom_range(0, 7));
      rd         = 5'($urandom_range(0, 7));
      rdata_a    = $urandom;
      rdata_b    = $urandom;
      imm        = $urandom;
      use_imm    = 1'($urandom_range(0, 1));
      dst_rt     = 1'($urandom_range(0, 1));
      sa         = 5'($urandom_range(0, 31));
      shift_op   = 2'($urandom_range(0, 3));
      arith_op   = 1'($urandom_range(0, 1));
      logical_op = 2'($urandom_range(0, 3));
      alu_sel    = 2'($urandom_range(0, 3));
      reg_write  = 1'($urandom_range(0, 1));
      mem_read   = ($urandom_range(0, 2) == 0);
      mem_write  = ($urandom_range(0, 4) == 0);
      exmem_rw   = 1'($urandom_range(0, 1));
      exmem_dst  = 5'($urandom_range(0, 7));
      exmem_data = $urandom;
      memwb_rw   = 1'($urandom_range(0, 1));
      memwb_dst  = 5'($urandom_range(0, 7));
      memwb_data = $urandom;
      go();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
